// File: rtl/pipe_regfile.sv
`default_nettype none
// ============================================================================
// pipe_regfile : 2R/1W register file with write bypass, pending scoreboard
//                and a multi-cycle soft-clear sweep.   Rev 1.0
// ============================================================================
module pipe_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]   rf_q, rf_d;
  logic [DEPTH-1:0]               pending_q, pending_d;

  logic wr_valid;
  logic sb_valid;
  logic ptr_last;

  assign clr_busy = (state_q == ST_SWEEP);
  assign ptr_last = (ptr_q == {ADDR_W{1'b1}});

  // Reset is folded in so nothing can be forwarded while it is held.
  assign wr_valid = wr_en && (wr_addr != '0) && !clr_busy && !reset;
  assign sb_valid = sb_set_en && (sb_set_addr != '0) && !clr_busy;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rf_d      = rf_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          rf_d[wr_addr]      = wr_data;
          pending_d[wr_addr] = 1'b0;
        end
        // Applied after the clear so an issue to the same register wins.
        if (sb_valid) begin
          pending_d[sb_set_addr] = 1'b1;
        end
        if (clr_start) begin
          state_d = ST_SWEEP;
          ptr_d   = ADDR_W'(1);
        end
      end
      ST_SWEEP: begin
        rf_d[ptr_q]      = '0;
        pending_d[ptr_q] = 1'b0;
        if (ptr_last) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    rf_d[0]      = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rf_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rf_q      <= rf_d;
      pending_q <= pending_d;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr_v;
  logic [1:0][DATA_W-1:0] rd_data_v;
  logic [1:0]             rs_pend_v;

  assign rd_addr_v = {rd_addr2, rd_addr1};

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic hit;
      assign hit = (BYPASS != 0) && wr_valid && (wr_addr == rd_addr_v[p]);
      assign rd_data_v[p] = (rd_addr_v[p] == '0) ? '0 :
                            hit                  ? wr_data :
                                                   rf_q[rd_addr_v[p]];
      assign rs_pend_v[p] = (rd_addr_v[p] != '0) && !hit && pending_q[rd_addr_v[p]];
    end
  endgenerate

  assign rd_data1    = rd_data_v[0];
  assign rd_data2    = rd_data_v[1];
  assign rs1_pending = rs_pend_v[0];
  assign rs2_pending = rs_pend_v[1];
  assign dbg_data    = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_pipe_regfile.sv
`default_nettype none
// Self-checking bench for pipe_regfile: directed scenarios followed by
// randomized traffic, compared against an array-based reference model.
module tb_pipe_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int BYPASS = 1;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, sb_set_addr, dbg_addr;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data, dbg_data;
  logic              rs1_pending, rs2_pending, wr_en, sb_set_en, clr_start, clr_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] m_rf   [DEPTH];
  logic              m_pend [DEPTH];
  int                m_left;

  always #5 clk = ~clk;

  pipe_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i]   = '0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
  endtask

  function automatic bit wr_ok();
    return !reset && wr_en && (wr_addr != 0) && (m_left == 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (BYPASS != 0 && wr_ok() && wr_addr == a) return wr_data;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] exp_pend(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (BYPASS != 0 && wr_ok() && wr_addr == a) return '0;
    return {31'd0, m_pend[a]};
  endfunction

  // Compare every output against the model for the currently driven inputs.
  task automatic settle();
    #1;
    if (reset) model_reset();
    check("rd_data1", rd_data1, exp_rd(rd_addr1));
    check("rd_data2", rd_data2, exp_rd(rd_addr2));
    check("rs1_pending", {31'd0, rs1_pending}, exp_pend(rd_addr1));
    check("rs2_pending", {31'd0, rs2_pending}, exp_pend(rd_addr2));
    check("clr_busy", {31'd0, clr_busy}, {31'd0, m_left != 0});
    check("dbg_data", dbg_data, m_rf[dbg_addr]);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (m_left > 0) begin
      m_rf[DEPTH - m_left]   = '0;
      m_pend[DEPTH - m_left] = 1'b0;
      m_left--;
    end else begin
      if (wr_ok()) begin
        m_rf[wr_addr]   = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
      if (clr_start) m_left = DEPTH - 1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    wr_en = 0; sb_set_en = 0; clr_start = 0;
    wr_addr = 0; wr_data = 0; sb_set_addr = 0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a); rd_addr2 = ADDR_W'(DEPTH - 1 - a); dbg_addr = ADDR_W'(a);
      settle();
      check(tag, rd_data1, 32'd0);
      advance();
    end
  endtask

  task automatic count_sweep(input string tag, input bit noisy);
    int cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (noisy) begin
        wr_en = 1; wr_addr = ADDR_W'($urandom_range(1, 31)); wr_data = $urandom;
        sb_set_en = 1; sb_set_addr = ADDR_W'($urandom_range(1, 31));
        clr_start = ($urandom_range(0, 3) == 0);
        rd_addr1 = wr_addr; rd_addr2 = ADDR_W'($urandom); dbg_addr = ADDR_W'($urandom);
      end
      settle();
      if (!clr_busy) break;
      cnt++;
      advance();
    end
    check(tag, cnt, 32'd31);
    idle_inputs();
  endtask

  initial begin
    model_reset();
    reset = 1; idle_inputs();
    rd_addr1 = 0; rd_addr2 = 0; dbg_addr = 0;
    @(negedge clk);

    // Everything reads zero while reset is held, even with a write offered.
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a); rd_addr2 = ADDR_W'(a); dbg_addr = ADDR_W'(a);
      wr_en = 1; wr_addr = ADDR_W'(a); wr_data = $urandom | 32'h1;
      settle();
      check("reset_rd1", rd_data1, 32'd0);
      advance();
    end
    idle_inputs();
    reset = 0;
    read_all_zero("post_reset_rd1");

    // Same-cycle bypass of a writeback.
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr1 = 5;
    settle();
    check("bypass_r5", rd_data1, BYPASS != 0 ? 32'hDEADBEEF : 32'd0);
    advance();
    idle_inputs();
    settle();
    check("r5_after", rd_data1, 32'hDEADBEEF);
    advance();

    // Register 0 is immune to writes and issues.
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
    sb_set_en = 1; sb_set_addr = 0; rd_addr1 = 0; rd_addr2 = 0; dbg_addr = 0;
    settle();
    check("r0_rd", rd_data1, 32'd0);
    advance();
    idle_inputs();
    settle();
    check("r0_rd_next", rd_data2, 32'd0);
    check("r0_pend", {31'd0, rs1_pending}, 32'd0);
    advance();

    // Set beats clear on the same register.
    sb_set_en = 1; sb_set_addr = 7; rd_addr1 = 7;
    advance();
    settle();
    check("r7_pend_set", {31'd0, rs1_pending}, 32'd1);
    wr_en = 1; wr_addr = 7; wr_data = 32'h1;
    advance();
    idle_inputs();
    settle();
    check("r7_set_wins", {31'd0, rs1_pending}, 32'd1);
    advance();
    wr_en = 1; wr_addr = 7; wr_data = 32'h2;
    advance();
    idle_inputs();
    settle();
    check("r7_cleared", {31'd0, rs1_pending}, 32'd0);
    check("r7_data", rd_data1, 32'h2);
    advance();

    // Full sweep with traffic that must be ignored.
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = ADDR_W'(i); wr_data = i; sb_set_en = 1; sb_set_addr = ADDR_W'(i);
      rd_addr1 = ADDR_W'(i); dbg_addr = ADDR_W'(i - 1);
      tick();
    end
    idle_inputs();
    clr_start = 1;
    tick();
    clr_start = 0;
    count_sweep("sweep_len", 1'b1);
    read_all_zero("after_sweep_rd1");

    // Reset aborts a sweep in progress.
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = ADDR_W'(i); wr_data = $urandom | 32'h1;
      sb_set_en = 1; sb_set_addr = ADDR_W'(i);
      tick();
    end
    idle_inputs();
    clr_start = 1;
    tick();
    clr_start = 0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1;
    settle();
    check("abort_busy", {31'd0, clr_busy}, 32'd0);
    advance();
    tick();
    reset = 0;
    read_all_zero("abort_rd1");
    clr_start = 1;
    tick();
    clr_start = 0;
    count_sweep("sweep_len_after_reset", 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      wr_en       = $urandom_range(0, 1);
      wr_addr     = ADDR_W'($urandom_range(0, 9));
      wr_data     = $urandom;
      sb_set_en   = $urandom_range(0, 1);
      sb_set_addr = ADDR_W'($urandom_range(0, 9));
      clr_start   = ($urandom_range(0, 99) == 0);
      rd_addr1    = ($urandom_range(0, 2) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 9));
      rd_addr2    = ($urandom_range(0, 2) == 0) ? sb_set_addr : ADDR_W'($urandom);
      dbg_addr    = ADDR_W'($urandom_range(0, 9));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
